// File: rtl/nibble_bus_pkg.sv
// Shared definitions for both ends of the 4-bit time-multiplexed nibble bus.
// The source-side quad 2:1 mux and the receive demux use the same select encodings.
package nibble_bus_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_A = 2'd1,
        FULL   = 2'd2
    } nb_state_e;

endpackage

// File: rtl/nibble_tmo_counter.sv
// Saturating wait counter for the HAVE_A state; flags expiry on the edge where
// the count reaches TIMEOUT. TIMEOUT=0 disables expiry entirely.
module nibble_tmo_counter #(
    parameter int TIMEOUT = 15,
    parameter int TCNT_W  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic              TMO_ON   = (TIMEOUT != 0);
    localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT - 1);
    localparam logic [TCNT_W-1:0] CNT_MAX  = {TCNT_W{1'b1}};

    logic [TCNT_W-1:0] cnt_r;

    // Count idle cycles; clear wins over enable, and the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {TCNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {TCNT_W{1'b0}};
        end else if (en && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + {{(TCNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = TMO_ON & en & ~clr & (cnt_r == TMO_LAST);

endmodule

// File: rtl/nibble_bus_demux.sv
// Receive side of the nibble bus: steers strobed A/B nibbles into holding
// registers, offers {B,A} on a valid/ready port and flags sequence/timeout/overrun.
module nibble_bus_demux
    import nibble_bus_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = 15,
    parameter int TCNT_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   bus_d,
    input  logic               bus_sel,
    input  logic               bus_en_n,
    output logic               bus_rdy,
    output logic [WIDTH-1:0]   a_q,
    output logic [WIDTH-1:0]   b_q,
    output logic               byte_valid,
    output logic [2*WIDTH-1:0] byte_data,
    input  logic               byte_ready,
    output logic               err_seq,
    output logic               err_tmo,
    output logic               err_ovr
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_HAVE_A = HAVE_A;
    localparam logic [1:0] S_FULL   = FULL;

    logic [1:0]       state_r, state_s;
    logic [WIDTH-1:0] a_q_r, a_q_s;
    logic [WIDTH-1:0] b_q_r, b_q_s;
    logic             valid_r, valid_s;
    logic             err_seq_r, err_seq_s;
    logic             err_tmo_r, err_tmo_s;
    logic             err_ovr_r, err_ovr_s;
    logic             strobe_s;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic             tmo_exp_s;

    assign strobe_s = ~bus_en_n;

    nibble_tmo_counter #(
        .TIMEOUT (TIMEOUT),
        .TCNT_W  (TCNT_W)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr_s),
        .en      (cnt_en_s),
        .expired (tmo_exp_s)
    );

    // Next-state and next-register decode; only one error source can fire per state.
    always_comb begin
        state_s   = state_r;
        a_q_s     = a_q_r;
        b_q_s     = b_q_r;
        valid_s   = valid_r;
        err_seq_s = 1'b0;
        err_tmo_s = 1'b0;
        err_ovr_s = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (strobe_s) begin
                    if (bus_sel == SEL_A) begin
                        a_q_s     = bus_d;
                        state_s   = S_HAVE_A;
                        cnt_clr_s = 1'b1;
                    end else begin
                        err_seq_s = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_HAVE_A: begin
                if (strobe_s) begin
                    if (bus_sel == SEL_B) begin
                        b_q_s   = bus_d;
                        valid_s = 1'b1;
                        state_s = S_FULL;
                    end else begin
                        a_q_s     = bus_d;
                        err_seq_s = 1'b1;
                        cnt_clr_s = 1'b1;
                    end
                end else begin
                    cnt_en_s = 1'b1;
                    if (tmo_exp_s) begin
                        err_tmo_s = 1'b1;
                        state_s   = S_IDLE;
                    end else begin
                        state_s = S_HAVE_A;
                    end
                end
            end
            S_FULL: begin
                if (byte_ready) begin
                    valid_s = 1'b0;
                    if (strobe_s && (bus_sel == SEL_A)) begin
                        a_q_s     = bus_d;
                        state_s   = S_HAVE_A;
                        cnt_clr_s = 1'b1;
                    end else if (strobe_s) begin
                        err_seq_s = 1'b1;
                        state_s   = S_IDLE;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else if (strobe_s) begin
                    // bus_rdy is low here, so the nibble is dropped and the byte kept.
                    err_ovr_s = 1'b1;
                end else begin
                    state_s = S_FULL;
                end
            end
            default: begin
                state_s = S_IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // State, holding registers and one-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            a_q_r     <= {WIDTH{1'b0}};
            b_q_r     <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            err_seq_r <= 1'b0;
            err_tmo_r <= 1'b0;
            err_ovr_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            a_q_r     <= a_q_s;
            b_q_r     <= b_q_s;
            valid_r   <= valid_s;
            err_seq_r <= err_seq_s;
            err_tmo_r <= err_tmo_s;
            err_ovr_r <= err_ovr_s;
        end
    end

    assign bus_rdy    = (state_r == S_FULL) ? byte_ready : 1'b1;
    assign a_q        = a_q_r;
    assign b_q        = b_q_r;
    assign byte_valid = valid_r;
    assign byte_data  = {b_q_r, a_q_r};
    assign err_seq    = err_seq_r;
    assign err_tmo    = err_tmo_r;
    assign err_ovr    = err_ovr_r;

endmodule
